// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the fetch redirect controller.
// Contents: default address width, refill counter width, redirect source
//           and FSM state enumerations.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  // Refill counter holds REFILL_CYCLES-1, with REFILL_CYCLES limited to 1..7.
  localparam int unsigned RC_W       = 3;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_EX1   = 3'd1,
    SRC_EX2   = 3'd2,
    SRC_JR    = 3'd3,
    SRC_STALL = 3'd4
  } redirect_src_e;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/redirect_prio_arb.sv
// Purpose: combinational priority encoder over the redirect/stall requests.
//   Priority order is ex_misp_1 > ex_misp_2 > id_jr > stall_req. id_jr and
//   stall_req are only eligible in IDLE, because during REFILL decode holds
//   wrong-path words.
// Ports:
//   state_i                      current controller state
//   ex_misp_1_i / ex_target_1_i  execute slot-1 mispredict and its target
//   ex_misp_2_i / ex_target_2_i  execute slot-2 mispredict and its target
//   id_jr_i / id_jr_target_i     decode jr and its target
//   stall_req_i                  decode stall request
//   src_o                        winning source
//   target_o                     target of the winner (0 when none)
module redirect_prio_arb
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  fsm_state_e          state_i,
  input  logic                ex_misp_1_i,
  input  logic [ADDR_W-1:0]   ex_target_1_i,
  input  logic                ex_misp_2_i,
  input  logic [ADDR_W-1:0]   ex_target_2_i,
  input  logic                id_jr_i,
  input  logic [ADDR_W-1:0]   id_jr_target_i,
  input  logic                stall_req_i,
  output redirect_src_e       src_o,
  output logic [ADDR_W-1:0]   target_o
);

  always_comb begin
    src_o    = SRC_NONE;
    target_o = '0;
    if (ex_misp_1_i) begin
      src_o    = SRC_EX1;
      target_o = ex_target_1_i;
    end else if (ex_misp_2_i) begin
      src_o    = SRC_EX2;
      target_o = ex_target_2_i;
    end else if (state_i == IDLE) begin
      if (id_jr_i) begin
        src_o    = SRC_JR;
        target_o = id_jr_target_i;
      end else if (stall_req_i) begin
        src_o    = SRC_STALL;
      end
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Purpose: sequencing controller for the dual-issue predict-not-taken fetch
//   stage. Picks a PC redirect source each cycle, drives the fetch unit's
//   correction/jr/hold inputs and the pipeline flush strobes, and tracks the
//   instruction-memory refill window after every redirect.
// Ports:
//   clk, rst                         clock, async active-high reset
//   ex_misp_1/2, ex_target_1/2       execute-stage mispredicts and targets
//   id_jr, id_jr_target              decode jr and forwarded target
//   stall_req                        decode hazard, freeze fetch
//   correct_en, correction           redirect fetch to a mispredict target
//   jr, reg1Addr                     redirect fetch to a jr target
//   hold                             freeze fetch PC
//   flush_if, flush_id, flush_ex2    squash strobes
//   busy                             controller in REFILL
//   stat_redirects, stat_stalls      saturating statistics (optional)
// Configuration: define FETCH_REDIRECT_STATS_EN to add the statistics
//   counters, their CNT_W parameter and output ports.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned REFILL_CYCLES = 1
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  parameter int unsigned CNT_W         = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_misp_1,
  input  logic [ADDR_W-1:0] ex_target_1,
  input  logic              ex_misp_2,
  input  logic [ADDR_W-1:0] ex_target_2,
  input  logic              id_jr,
  input  logic [ADDR_W-1:0] id_jr_target,
  input  logic              stall_req,
  output logic              correct_en,
  output logic [ADDR_W-1:0] correction,
  output logic              jr,
  output logic [ADDR_W-1:0] reg1Addr,
  output logic              hold,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_ex2,
  output logic              busy
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_redirects,
  output logic [CNT_W-1:0]  stat_stalls
`endif
);

  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFILL_CYCLES - 1);

  fsm_state_e        state_q, state_d;
  logic [RC_W-1:0]   cnt_q, cnt_d;
  redirect_src_e     src;
  logic [ADDR_W-1:0] sel_target;
  logic [ADDR_W-1:0] correction_q;
  logic [ADDR_W-1:0] reg1_addr_q;
  logic              ex_redirect;
  logic              redirect;

  redirect_prio_arb #(.ADDR_W(ADDR_W)) u_arb (
    .state_i        (state_q),
    .ex_misp_1_i    (ex_misp_1),
    .ex_target_1_i  (ex_target_1),
    .ex_misp_2_i    (ex_misp_2),
    .ex_target_2_i  (ex_target_2),
    .id_jr_i        (id_jr),
    .id_jr_target_i (id_jr_target),
    .stall_req_i    (stall_req),
    .src_o          (src),
    .target_o       (sel_target)
  );

  assign ex_redirect = (src == SRC_EX1) || (src == SRC_EX2);
  assign redirect    = ex_redirect || (src == SRC_JR);

  // State and refill counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: any redirect (re)starts the refill window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      state_d = REFILL;
      cnt_d   = RC_LOAD;
    end else if (state_q == REFILL) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - RC_W'(1);
    end
  end

  // Last-issued targets, so correction/reg1Addr stay stable when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      correction_q <= '0;
      reg1_addr_q  <= '0;
    end else begin
      if (ex_redirect)   correction_q <= sel_target;
      if (src == SRC_JR) reg1_addr_q  <= sel_target;
    end
  end

  // Outputs follow the arbiter in the same cycle; rst forces everything low.
  always_comb begin
    correct_en = 1'b0;
    correction = '0;
    jr         = 1'b0;
    reg1Addr   = '0;
    hold       = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    flush_ex2  = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      correction = correction_q;
      reg1Addr   = reg1_addr_q;
      busy       = (state_q == REFILL);
      flush_if   = (state_q == REFILL);
      unique case (src)
        SRC_EX1, SRC_EX2: begin
          correct_en = 1'b1;
          correction = sel_target;
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          // Slot 2 is younger than a mispredicting slot 1, so squash it.
          flush_ex2  = (src == SRC_EX1);
        end
        SRC_JR: begin
          jr       = 1'b1;
          reg1Addr = sel_target;
          flush_if = 1'b1;
        end
        SRC_STALL: hold = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FETCH_REDIRECT_STATS_EN
  logic [CNT_W-1:0] stat_redirects_q;
  logic [CNT_W-1:0] stat_stalls_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_redirects_q <= '0;
      stat_stalls_q    <= '0;
    end else begin
      if (redirect && !(&stat_redirects_q))
        stat_redirects_q <= stat_redirects_q + CNT_W'(1);
      if ((src == SRC_STALL) && !(&stat_stalls_q))
        stat_stalls_q <= stat_stalls_q + CNT_W'(1);
    end
  end

  assign stat_redirects = stat_redirects_q;
  assign stat_stalls    = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl. Two instances share
// the stimulus: d1 with REFILL_CYCLES=1 and d3 with REFILL_CYCLES=3.
// Flag vectors are {correct_en, jr, hold, flush_if, flush_id, flush_ex2, busy}.
module tb_fetch_redirect_ctrl;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_misp_1, ex_misp_2, id_jr, stall_req;
  logic [AW-1:0] ex_target_1, ex_target_2, id_jr_target;

  logic          c1_en, j1, h1, fi1, fid1, fx1, b1;
  logic [AW-1:0] corr1, r1;
  logic          c3_en, j3, h3, fi3, fid3, fx3, b3;
  logic [AW-1:0] corr3, r3;
  logic [6:0]    f1, f3;

`ifdef FETCH_REDIRECT_STATS_EN
  logic [3:0]    sr1, ss1, sr3, ss3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign f1 = {c1_en, j1, h1, fi1, fid1, fx1, b1};
  assign f3 = {c3_en, j3, h3, fi3, fid3, fx3, b3};

  fetch_redirect_ctrl #(
    .ADDR_W(AW), .REFILL_CYCLES(1)
`ifdef FETCH_REDIRECT_STATS_EN
    , .CNT_W(4)
`endif
  ) d1 (
    .clk(clk), .rst(rst),
    .ex_misp_1(ex_misp_1), .ex_target_1(ex_target_1),
    .ex_misp_2(ex_misp_2), .ex_target_2(ex_target_2),
    .id_jr(id_jr), .id_jr_target(id_jr_target), .stall_req(stall_req),
    .correct_en(c1_en), .correction(corr1), .jr(j1), .reg1Addr(r1),
    .hold(h1), .flush_if(fi1), .flush_id(fid1), .flush_ex2(fx1), .busy(b1)
`ifdef FETCH_REDIRECT_STATS_EN
    , .stat_redirects(sr1), .stat_stalls(ss1)
`endif
  );

  fetch_redirect_ctrl #(
    .ADDR_W(AW), .REFILL_CYCLES(3)
`ifdef FETCH_REDIRECT_STATS_EN
    , .CNT_W(4)
`endif
  ) d3 (
    .clk(clk), .rst(rst),
    .ex_misp_1(ex_misp_1), .ex_target_1(ex_target_1),
    .ex_misp_2(ex_misp_2), .ex_target_2(ex_target_2),
    .id_jr(id_jr), .id_jr_target(id_jr_target), .stall_req(stall_req),
    .correct_en(c3_en), .correction(corr3), .jr(j3), .reg1Addr(r3),
    .hold(h3), .flush_if(fi3), .flush_id(fid3), .flush_ex2(fx3), .busy(b3)
`ifdef FETCH_REDIRECT_STATS_EN
    , .stat_redirects(sr3), .stat_stalls(ss3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_misp_1 = 1'b0; ex_misp_2 = 1'b0; id_jr = 1'b0; stall_req = 1'b0;
    ex_target_1 = '0; ex_target_2 = '0; id_jr_target = '0;
    settle();
    check("reset_flags", f1, 7'b0000000);
    check("reset_corr", corr1, 0);
    step();
    rst = 1'b0;

    // Reset in the middle of a refill window
    ex_misp_1 = 1'b1; ex_target_1 = 10'h123;
    settle();
    check("t1_redirect", f1, 7'b1001110);
    step();
    ex_misp_1 = 1'b1;
    rst = 1'b1;
    settle();
    check("t1_rst_flags", f1, 7'b0000000);
    check("t1_rst_corr", corr1, 0);
    check("t1_rst_flags_d3", f3, 7'b0000000);
    step();
    rst = 1'b0; ex_misp_1 = 1'b0;
    settle();
    check("t1_post_flags", f1, 7'b0000000);
    check("t1_post_corr", corr1, 0);

    // Slot-2 mispredict with one refill cycle
    step();
    ex_misp_2 = 1'b1; ex_target_2 = 10'h05A;
    settle();
    check("t2_flags", f1, 7'b1001100);
    check("t2_corr", corr1, 10'h05A);
    step();
    ex_misp_2 = 1'b0;
    settle();
    check("t2_refill", f1, 7'b0001001);
    check("t2_corr_held", corr1, 10'h05A);
    step();
    settle();
    check("t2_idle", f1, 7'b0000000);

    // Three simultaneous redirect requests
    ex_misp_1 = 1'b1; ex_target_1 = 10'h010;
    ex_misp_2 = 1'b1; ex_target_2 = 10'h020;
    id_jr = 1'b1;     id_jr_target = 10'h030;
    settle();
    check("t3_flags", f1, 7'b1001110);
    check("t3_corr", corr1, 10'h010);
    check("t3_reg1", r1, 0);
    step();
    ex_misp_1 = 1'b0; ex_misp_2 = 1'b0; id_jr = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Plain stall for three cycles
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t4_hold%0d", i), f1, 7'b0010000);
      step();
    end
    stall_req = 1'b0;
    settle();
    check("t4_unhold", f1, 7'b0000000);
    step();

    // Stall interrupted by a jr
    stall_req = 1'b1;
    settle();
    check("t4b_hold", f1, 7'b0010000);
    step();
    id_jr = 1'b1; id_jr_target = 10'h3FF;
    settle();
    check("t4b_jr_flags", f1, 7'b0101000);
    check("t4b_reg1", r1, 10'h3FF);
    step();
    id_jr = 1'b0;
    settle();
    check("t4b_refill", f1, 7'b0001001);
    step();
    stall_req = 1'b0;
    settle();
    check("t4b_idle", f1, 7'b0000000);
`ifdef FETCH_REDIRECT_STATS_EN
    check("stat_redir_3", sr1, 4'd3);
    check("stat_stall_4", ss1, 4'd4);
`endif
    for (int i = 0; i < 4; i++) step();

    // Three-cycle refill ignores jr
    ex_misp_1 = 1'b1; ex_target_1 = 10'h100;
    settle();
    check("t5_redirect", f3, 7'b1001110);
    step();
    ex_misp_1 = 1'b0; id_jr = 1'b1; id_jr_target = 10'h200;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t5_refill%0d", i), f3, 7'b0001001);
      step();
    end
    settle();
    check("t5_jr_taken", f3, 7'b0101000);
    check("t5_reg1", r3, 10'h200);
    step();
    id_jr = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Mispredict inside refill reloads the counter
    ex_misp_1 = 1'b1; ex_target_1 = 10'h100;
    settle();
    check("t5b_redirect", f3, 7'b1001110);
    step();
    ex_misp_1 = 1'b0;
    settle();
    check("t5b_refill0", f3, 7'b0001001);
    step();
    ex_misp_1 = 1'b1; ex_target_1 = 10'h111;
    settle();
    check("t5b_reload", f3, 7'b1001111);
    check("t5b_corr", corr3, 10'h111);
    step();
    ex_misp_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t5b_refill%0d", i + 1), f3, 7'b0001001);
      step();
    end
    settle();
    check("t5b_idle", f3, 7'b0000000);
    check("t5b_corr_held", corr3, 10'h111);

`ifdef FETCH_REDIRECT_STATS_EN
    // Counter saturation
    ex_misp_2 = 1'b1; ex_target_2 = 10'h055;
    for (int i = 0; i < 20; i++) step();
    ex_misp_2 = 1'b0;
    settle();
    check("stat_redir_sat", sr1, 4'hF);
    check("stat_stall_keep", ss1, 4'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
